control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Hardwired control unit placed directly upstream of Datapath; generates the per-cycle control strobes for fetch and execute (pc_out, mar_enable, read, ir_enable, y_enable, z_enable, register in/out selects, op_code and so on).
- Consumes the Datapath IR output and sequences one instruction at a time through T0..T6, one state per clock.
- Covers ALU register ops, immediate ALU ops, neg/not and mul/div. Load/store are outside this block's scope.

Parameters:
- NUM_REGS, 16, general register count; width of the one-hot select buses.
- OPW, 5, opcode width, IR[31:27].

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clr  input  1  reset, asynchronous, active-high.
- run  input  1  high = keep fetching; low = park in IDLE after the current instruction.
- ir  input  32  Datapath IR contents; valid from T3 onward.
- pc_out, mdr_out, zlo_out, zhi_out, c_out  output  1 each  bus drive selects; c_out drives sign-extended IR[18:0].
- mar_enable, mdr_enable, ir_enable, y_enable, z_enable, pc_increment, read, lo_enable, hi_enable  output  1 each  load/control strobes.
- r_out  output  NUM_REGS  one-hot register bus-drive select.
- r_enable  output  NUM_REGS  one-hot register load select.
- op_code  output  OPW  ALU operation; 0 outside ALU-compute cycles.
- illegal  output  1  high while in HALT.

Behaviour:
- IR fields: opcode = ir[31:27], ra = ir[26:23], rb = ir[22:19], rc = ir[18:15].
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. The state register is the only storage.
- All outputs are combinational decode of state and ir. Outputs are all 0 in IDLE and HALT, except illegal = 1 in HALT.
- clr is asynchronous and forces state to IDLE immediately, including mid-instruction (for example during T4 with z_enable high); all outputs drop to 0 in the same instant.
- IDLE: to T0 when run = 1, else stay.
- Fetch, common to all instructions:
  - T0: pc_out, mar_enable, pc_increment.
  - T1: read, mdr_enable.
  - T2: mdr_out, ir_enable. Next state is T3.
- T3 decode of opcode:
  - Register ops (add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011):
    - T3: r_out[rb], y_enable.
    - T4: r_out[rc], op_code = opcode, z_enable.
    - T5: zlo_out, r_enable[ra]. Done.
  - Immediate ops (addi 01100, andi 01101, ori 01110): same as register ops, except T4 asserts c_out instead of r_out[rc].
  - neg 10001, not 10010:
    - T3: r_out[rb], op_code = opcode, z_enable.
    - T4: zlo_out, r_enable[ra]. Done.
  - div 01111, mul 10000:
    - T3: r_out[ra], y_enable.
    - T4: r_out[rb], op_code = opcode, z_enable.
    - T5: zlo_out, lo_enable.
    - T6: zhi_out, hi_enable. Done.
  - Any other opcode (ld, ldi, st, and 10011 to 11111): T3 asserts nothing and the next state is HALT.
- Done: next state is T0 if run = 1, else IDLE. run is sampled only at the done edge and in IDLE.
- HALT: exits only via clr.
- Instruction length: 6 clocks for register/immediate ops, 5 for neg/not, 7 for mul/div.
- Selects: r_out and r_enable are exactly one-hot when active, zero otherwise. R0 is writable (no special case).
- At most one bus-drive select (pc_out, mdr_out, zlo_out, zhi_out, c_out, any r_out bit) is high in any cycle.

Decomposition:
- Shared package cpu_pkg:
  - opcode localparams (ld..not, 5-bit, values above);
  - state encoding enum;
  - IR field bit positions.
- One natural sub-module: reg_select_decoder, which maps a 4-bit field plus a valid flag to a NUM_REGS one-hot vector. It is instantiated twice, once for r_out and once for r_enable.

Test Plan:
- Reset then run = 1, ir = 0x321B8000 (or R4,R3,R7):
  - T0..T2 strobes as listed.
  - T3: r_out = 0x0008, y_enable.
  - T4: r_out = 0x0080, op_code = 00110, z_enable.
  - T5: zlo_out, r_enable = 0x0010.
  - Next cycle is T0.
- ir = 0x6A180005 (andi R4,R3,5): T4 asserts c_out, r_out = 0, op_code = 01101; T5 r_enable = 0x0010; 6 clocks total.
- ir = 0x81980000 (mul R3,R3): T3 r_out = 0x0008 with y_enable; T5 zlo_out + lo_enable; T6 zhi_out + hi_enable; 7 clocks total.
- ir = 0x00000000 (ld): after T2, HALT with illegal = 1 and all other outputs 0; it stays halted for 10 clocks regardless of run; clr returns it to IDLE with illegal = 0.
- run dropped during T4 of an or instruction: T5 completes, then IDLE; all outputs 0 until run = 1.
- clr pulsed asynchronously mid-T4: z_enable and r_out fall without waiting for a clock edge; the state is IDLE at the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, IR field
// positions, sequencer state encoding and opcode classification.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_REG, CLS_IMM, CLS_UNARY, CLS_MULDIV, CLS_ILLEGAL
    } op_class_e;

    // Groups opcodes by the shape of their execute sequence.
    function automatic op_class_e classifyOp(input logic [4:0] opc);
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:   return CLS_REG;
            OP_ADDI, OP_ANDI, OP_ORI:          return CLS_IMM;
            OP_NEG, OP_NOT:                    return CLS_UNARY;
            OP_DIV, OP_MUL:                    return CLS_MULDIV;
            OP_LD, OP_LDI, OP_ST:              return CLS_ILLEGAL;
            default:                           return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Turns a 4-bit register field into a one-hot select vector, all zero
// when the select is not active this cycle.
module reg_select_decoder #(
    parameter int NUM_REGS = 16
) (
    input  logic [3:0]          field_i,
    input  logic                valid_i,
    output logic [NUM_REGS-1:0] onehot_o
);

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot_o[i] = valid_i && (field_i == 4'(i));
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: walks each instruction through fetch (T0..T2)
// and execute (T3..T6), decoding per-cycle datapath strobes from state and IR.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int OPW      = 5
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                run,
    input  logic [31:0]         ir,
    output logic                pc_out,
    output logic                mdr_out,
    output logic                zlo_out,
    output logic                zhi_out,
    output logic                c_out,
    output logic                mar_enable,
    output logic                mdr_enable,
    output logic                ir_enable,
    output logic                y_enable,
    output logic                z_enable,
    output logic                pc_increment,
    output logic                read,
    output logic                lo_enable,
    output logic                hi_enable,
    output logic [NUM_REGS-1:0] r_out,
    output logic [NUM_REGS-1:0] r_enable,
    output logic [OPW-1:0]      op_code,
    output logic                illegal
);

    state_e    state_q, state_d;
    op_class_e opClass;
    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic [3:0] rOutField, rEnField;
    logic       rOutValid, rEnValid, done;
    logic       unusedIr;

    assign opcode   = ir[OPC_MSB:OPC_LSB];
    assign ra       = ir[RA_MSB:RA_LSB];
    assign rb       = ir[RB_MSB:RB_LSB];
    assign rc       = ir[RC_MSB:RC_LSB];
    assign opClass  = classifyOp(opcode);
    // The immediate bits are routed to the bus by the datapath, not here.
    assign unusedIr = ^ir[RC_LSB-1:0];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        pc_out       = 1'b0;
        mdr_out      = 1'b0;
        zlo_out      = 1'b0;
        zhi_out      = 1'b0;
        c_out        = 1'b0;
        mar_enable   = 1'b0;
        mdr_enable   = 1'b0;
        ir_enable    = 1'b0;
        y_enable     = 1'b0;
        z_enable     = 1'b0;
        pc_increment = 1'b0;
        read         = 1'b0;
        lo_enable    = 1'b0;
        hi_enable    = 1'b0;
        op_code      = '0;
        illegal      = 1'b0;
        rOutField    = 4'd0;
        rOutValid    = 1'b0;
        rEnField     = 4'd0;
        rEnValid     = 1'b0;
        done         = 1'b0;
        case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0: begin
                pc_out = 1'b1; mar_enable = 1'b1; pc_increment = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                read = 1'b1; mdr_enable = 1'b1;
                state_d = S_T2;
            end
            S_T2: begin
                mdr_out = 1'b1; ir_enable = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                state_d = S_T4;
                case (opClass)
                    CLS_REG, CLS_IMM: begin
                        rOutField = rb; rOutValid = 1'b1; y_enable = 1'b1;
                    end
                    CLS_UNARY: begin
                        rOutField = rb; rOutValid = 1'b1;
                        op_code = OPW'(opcode); z_enable = 1'b1;
                    end
                    CLS_MULDIV: begin
                        rOutField = ra; rOutValid = 1'b1; y_enable = 1'b1;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_T4: begin
                state_d = S_T5;
                case (opClass)
                    CLS_REG: begin
                        rOutField = rc; rOutValid = 1'b1;
                        op_code = OPW'(opcode); z_enable = 1'b1;
                    end
                    CLS_IMM: begin
                        c_out = 1'b1; op_code = OPW'(opcode); z_enable = 1'b1;
                    end
                    CLS_UNARY: begin
                        zlo_out = 1'b1; rEnField = ra; rEnValid = 1'b1;
                        done = 1'b1;
                    end
                    CLS_MULDIV: begin
                        rOutField = rb; rOutValid = 1'b1;
                        op_code = OPW'(opcode); z_enable = 1'b1;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_T5: begin
                case (opClass)
                    CLS_REG, CLS_IMM: begin
                        zlo_out = 1'b1; rEnField = ra; rEnValid = 1'b1;
                        done = 1'b1;
                    end
                    CLS_MULDIV: begin
                        zlo_out = 1'b1; lo_enable = 1'b1;
                        state_d = S_T6;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_T6: begin
                zhi_out = 1'b1; hi_enable = 1'b1;
                done = 1'b1;
            end
            S_HALT: illegal = 1'b1;
            default: state_d = S_IDLE;
        endcase
        // run is only consulted at instruction boundaries.
        if (done) state_d = run ? S_T0 : S_IDLE;
    end

    reg_select_decoder #(.NUM_REGS(NUM_REGS)) uROutDecoder (
        .field_i  (rOutField),
        .valid_i  (rOutValid),
        .onehot_o (r_out)
    );

    reg_select_decoder #(.NUM_REGS(NUM_REGS)) uREnDecoder (
        .field_i  (rEnField),
        .valid_i  (rEnValid),
        .onehot_o (r_enable)
    );

endmodule
